// File: rtl/hb_pkg.sv
// Shared types and constants for the heartbeat pattern generator.
//   hb_mode_e  : runtime output mode (OFF / FREE square / BLINK code / SOLID)
//   hb_state_e : sequencer state (IDLE / RUN / GAP)
package hb_pkg;

  typedef enum logic [1:0] {
    HB_OFF   = 2'd0,
    HB_FREE  = 2'd1,
    HB_BLINK = 2'd2,
    HB_SOLID = 2'd3
  } hb_mode_e;

  typedef enum logic [1:0] {
    HB_IDLE = 2'd0,
    HB_RUN  = 2'd1,
    HB_GAP  = 2'd2
  } hb_state_e;

  // Shortest period that still has one high and one low cycle.
  localparam int unsigned HB_MIN_PERIOD = 2;

endpackage

// File: rtl/hb_period_cnt.sv
// Period counter: counts 0..period_m1 while running, wraps on the last cycle,
// and flags both the last cycle and the "still inside high time" window.
//   clk, reset_n  : clock, async active-low reset
//   i_run         : advance when high, hold at zero when low
//   i_period_m1   : last count value of the period (already clamped, >= 1)
//   i_high        : number of high cycles at the start of each period
//   o_last_c      : combinational, current count is the last of the period
//   o_high_c      : combinational, current count is below the high time
module hb_period_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_period_m1,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_last_c,
  output logic             o_high_c
);

  logic [CNT_W-1:0] r_cnt;

  // >= rather than == so the counter can never run past the period end.
  assign o_last_c = (r_cnt >= i_period_m1);
  assign o_high_c = (r_cnt < i_high);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (o_last_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hb_pattern_gen.sv
// Heartbeat / status pattern generator with programmable period, high time
// and mode (OFF, FREE square wave, BLINK code bursts, SOLID on).
// New configuration is shadowed and only takes effect on a period boundary
// (or immediately from IDLE) so the visible waveform never glitches.
//   clk, reset_n   : clock, async active-low reset
//   enable         : run generator; low forces output low and returns to IDLE
//   cfg_load       : one-cycle strobe capturing mode/period/high_time/blink_cnt
//   mode           : 0=OFF 1=FREE 2=BLINK 3=SOLID
//   period         : cycles per period
//   high_time      : high cycles per period
//   blink_cnt      : pulses per burst in BLINK mode
//   hb_pulse       : registered heartbeat output
//   period_strobe  : registered pulse for the last cycle of every period
//   cfg_pending    : captured configuration not yet applied
module hb_pattern_gen #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned PERIOD_DEF  = 64,
  parameter int unsigned HIGH_DEF    = 32,
  parameter int unsigned BLINK_W     = 4,
  parameter int unsigned GAP_PERIODS = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high_time,
  input  logic [BLINK_W-1:0] blink_cnt,
  output logic               hb_pulse,
  output logic               period_strobe,
  output logic               cfg_pending
);

  import hb_pkg::*;

  localparam int unsigned GAP_W = (GAP_PERIODS > 1) ? $clog2(GAP_PERIODS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_PERIODS > 0) ? GAP_PERIODS - 1 : 0);

  hb_state_e          r_state;
  logic [BLINK_W-1:0] r_blink_idx;
  logic [GAP_W-1:0]   r_gap_idx;
  logic               r_hb;
  logic               r_strobe;

  // Active configuration (already clamped) and pending shadow copy.
  hb_mode_e           r_mode;
  logic [CNT_W-1:0]   r_period_m1;
  logic [CNT_W-1:0]   r_high;
  logic [BLINK_W-1:0] r_blink;
  logic               r_pending;
  hb_mode_e           r_pend_mode;
  logic [CNT_W-1:0]   r_pend_period;
  logic [CNT_W-1:0]   r_pend_high;
  logic [BLINK_W-1:0] r_pend_blink;

  logic               w_run;
  logic               w_last_c;
  logic               w_high_c;
  logic               w_apply;
  logic [CNT_W-1:0]   w_clamp_period;
  logic [CNT_W-1:0]   w_clamp_pm1;
  logic [CNT_W-1:0]   w_clamp_high;
  hb_mode_e           w_nxt_mode;
  logic [BLINK_W-1:0] w_nxt_blink;
  hb_state_e          w_burst_state;
  logic               w_blink_done;
  logic               w_gap_done;

  assign w_run = enable && (r_state != HB_IDLE);

  hb_period_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_run      (w_run),
    .i_period_m1(r_period_m1),
    .i_high     (r_high),
    .o_last_c   (w_last_c),
    .o_high_c   (w_high_c)
  );

  // Pending config is applied on a period boundary, or straight away from IDLE.
  assign w_apply = r_pending && enable && ((r_state == HB_IDLE) || w_last_c);

  // Clamp the pending timing so the counter always has a reachable end.
  assign w_clamp_period = (r_pend_period < CNT_W'(HB_MIN_PERIOD)) ? CNT_W'(HB_MIN_PERIOD)
                                                                  : r_pend_period;
  assign w_clamp_pm1    = w_clamp_period - CNT_W'(1);
  assign w_clamp_high   = (r_pend_high >= w_clamp_period) ? w_clamp_pm1 : r_pend_high;

  assign w_blink_done = ({1'b0, r_blink_idx} + (BLINK_W+1)'(1)) >= {1'b0, r_blink};
  assign w_gap_done   = (r_gap_idx >= GAP_LAST);

  // State to enter when a new burst starts, using the config valid after this edge.
  always_comb begin
    w_nxt_mode    = w_apply ? r_pend_mode : r_mode;
    w_nxt_blink   = w_apply ? r_pend_blink : r_blink;
    w_burst_state = HB_RUN;
    if (w_nxt_mode == HB_OFF) begin
      w_burst_state = HB_IDLE;
    end else if ((w_nxt_mode == HB_BLINK) && (w_nxt_blink == '0)) begin
      w_burst_state = HB_GAP;
    end
  end

  // Config shadowing, sequencer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= HB_IDLE;
      r_blink_idx   <= '0;
      r_gap_idx     <= '0;
      r_hb          <= 1'b0;
      r_strobe      <= 1'b0;
      r_mode        <= HB_FREE;
      r_period_m1   <= CNT_W'(PERIOD_DEF - 1);
      r_high        <= CNT_W'(HIGH_DEF);
      r_blink       <= BLINK_W'(1);
      r_pending     <= 1'b0;
      r_pend_mode   <= HB_OFF;
      r_pend_period <= '0;
      r_pend_high   <= '0;
      r_pend_blink  <= '0;
    end else begin
      // A load coincident with an apply lands in the shadow for the next boundary.
      r_pending <= cfg_load || (r_pending && !w_apply);
      if (cfg_load) begin
        r_pend_mode   <= hb_mode_e'(mode);
        r_pend_period <= period;
        r_pend_high   <= high_time;
        r_pend_blink  <= blink_cnt;
      end
      if (w_apply) begin
        r_mode      <= r_pend_mode;
        r_period_m1 <= w_clamp_pm1;
        r_high      <= w_clamp_high;
        r_blink     <= r_pend_blink;
      end

      if (!enable) begin
        r_state     <= HB_IDLE;
        r_hb        <= 1'b0;
        r_strobe    <= 1'b0;
        r_blink_idx <= '0;
        r_gap_idx   <= '0;
      end else begin
        case (r_state)
          HB_IDLE: begin
            r_hb        <= 1'b0;
            r_strobe    <= 1'b0;
            r_blink_idx <= '0;
            r_gap_idx   <= '0;
            r_state     <= w_burst_state;
          end
          HB_RUN: begin
            r_hb     <= (r_mode == HB_SOLID) || w_high_c;
            r_strobe <= w_last_c;
            if (w_last_c) begin
              if (w_apply) begin
                r_state     <= w_burst_state;
                r_blink_idx <= '0;
                r_gap_idx   <= '0;
              end else if (r_mode == HB_BLINK) begin
                if (w_blink_done) begin
                  r_state     <= HB_GAP;
                  r_blink_idx <= '0;
                  r_gap_idx   <= '0;
                end else begin
                  r_blink_idx <= r_blink_idx + BLINK_W'(1);
                end
              end
            end
          end
          HB_GAP: begin
            r_hb     <= 1'b0;
            r_strobe <= w_last_c;
            if (w_last_c) begin
              if (w_apply || w_gap_done) begin
                r_state     <= w_burst_state;
                r_blink_idx <= '0;
                r_gap_idx   <= '0;
              end else begin
                r_gap_idx <= r_gap_idx + GAP_W'(1);
              end
            end
          end
          default: begin
            r_state  <= HB_IDLE;
            r_hb     <= 1'b0;
            r_strobe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hb_pulse      = r_hb;
  assign period_strobe = r_strobe;
  assign cfg_pending   = r_pending;

endmodule

// File: tb/tb_hb_pattern_gen.sv
// Testbench for hb_pattern_gen: hand-derived vector table, directed corner
// sequences and randomized traffic against a period-index reference model.
module tb_hb_pattern_gen;

  localparam int GAP = 3;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        cfg_load;
  logic [1:0]  mode;
  logic [31:0] period;
  logic [31:0] high_time;
  logic [3:0]  blink_cnt;
  logic        hb_pulse;
  logic        period_strobe;
  logic        cfg_pending;

  hb_pattern_gen #(
    .CNT_W(32), .PERIOD_DEF(64), .HIGH_DEF(32), .BLINK_W(4), .GAP_PERIODS(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_load(cfg_load),
    .mode(mode), .period(period), .high_time(high_time), .blink_cnt(blink_cnt),
    .hb_pulse(hb_pulse), .period_strobe(period_strobe), .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: each period has an index k inside a burst cycle of
  // blink_cnt lit periods followed by GAP dark periods.
  bit     m_run;
  longint m_pos, m_k, m_mode, m_per, m_hi, m_bc;
  bit     p_valid;
  longint p_mode, p_per, p_hi, p_bc;
  bit     e_hb, e_st;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_k = 0;
    m_mode = 1; m_per = 64; m_hi = 32; m_bc = 1;
    p_valid = 0; e_hb = 0; e_st = 0;
  endtask

  task automatic model_apply();
    m_mode  = p_mode;
    m_per   = (p_per < 2) ? 2 : p_per;
    m_hi    = (p_hi >= m_per) ? m_per - 1 : p_hi;
    m_bc    = p_bc;
    p_valid = 0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input longint md,
                            input longint per, input longint hi, input longint bc);
    if (!en) begin
      m_run = 0; m_pos = 0; m_k = 0; e_hb = 0; e_st = 0;
    end else if (!m_run) begin
      e_hb = 0; e_st = 0;
      if (p_valid) model_apply();
      m_run = (m_mode != 0); m_pos = 0; m_k = 0;
    end else begin
      e_st = (m_pos == m_per - 1);
      e_hb = (m_mode == 3) || (((m_mode != 2) || (m_k < m_bc)) && (m_pos < m_hi));
      if (e_st) begin
        m_pos = 0;
        if (p_valid) begin
          model_apply(); m_k = 0; m_run = (m_mode != 0);
        end else if (m_mode == 2) begin
          m_k = (m_k + 1) % (m_bc + GAP);
        end
      end else begin
        m_pos++;
      end
    end
    if (ld) begin
      p_valid = 1; p_mode = md; p_per = per; p_hi = hi; p_bc = bc;
    end
  endtask

  task automatic step(input bit e, input bit l, input logic [1:0] md,
                      input logic [31:0] p, input logic [31:0] h, input logic [3:0] b);
    enable = e; cfg_load = l; mode = md; period = p; high_time = h; blink_cnt = b;
    @(posedge clk);
    model_edge(e, l, longint'(md), longint'(p), longint'(h), longint'(b));
    #1;
    chk("hb_pulse", hb_pulse, e_hb);
    chk("period_strobe", period_strobe, e_st);
    chk("cfg_pending", cfg_pending, p_valid);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; cfg_load = 1'b0;
    mode = 2'd0; period = '0; high_time = '0; blink_cnt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  typedef struct {
    bit en; bit ld; logic [1:0] md; logic [31:0] per; logic [31:0] hi; logic [3:0] bc;
    bit hb; bit st; bit pd;
  } vec_t;

  vec_t tbl[23];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clamp to 2/1, SOLID, OFF at boundary, BLINK with zero pulses.
    tbl[0]  = '{1, 1, 2'd1, 32'd1, 32'd5, 4'd0, 0, 0, 1};
    tbl[1]  = '{0, 0, 2'd0, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 2'd0, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 2'd0, 0, 0, 0, 0, 1, 0};
    tbl[5]  = '{1, 0, 2'd0, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{1, 1, 2'd3, 32'd3, 32'd0, 4'd0, 0, 1, 1};
    tbl[7]  = '{1, 0, 2'd0, 0, 0, 0, 1, 0, 1};
    tbl[8]  = '{1, 0, 2'd0, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1, 0, 2'd0, 0, 0, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 2'd0, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{1, 0, 2'd0, 0, 0, 0, 1, 1, 0};
    tbl[12] = '{1, 1, 2'd0, 32'd3, 32'd1, 4'd0, 1, 0, 1};
    tbl[13] = '{1, 0, 2'd0, 0, 0, 0, 1, 0, 1};
    tbl[14] = '{1, 0, 2'd0, 0, 0, 0, 1, 1, 0};
    tbl[15] = '{1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{1, 1, 2'd2, 32'd2, 32'd1, 4'd0, 0, 0, 1};
    tbl[18] = '{1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[20] = '{1, 0, 2'd0, 0, 0, 0, 0, 1, 0};
    tbl[21] = '{1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[22] = '{1, 0, 2'd0, 0, 0, 0, 0, 1, 0};

    do_reset();
    chk("reset_hb", hb_pulse, 1'b0);
    chk("reset_strobe", period_strobe, 1'b0);
    chk("reset_pending", cfg_pending, 1'b0);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].en, tbl[i].ld, tbl[i].md, tbl[i].per, tbl[i].hi, tbl[i].bc);
      chk($sformatf("tbl%0d_hb", i), hb_pulse, tbl[i].hb);
      chk($sformatf("tbl%0d_st", i), period_strobe, tbl[i].st);
      chk($sformatf("tbl%0d_pd", i), cfg_pending, tbl[i].pd);
    end

    // Default FREE 64/32 waveform, then async reset in the middle of a high phase.
    do_reset();
    for (int i = 0; i < 131; i++) begin
      step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
      chk("free_hb", hb_pulse, (i >= 1) && (((i - 1) % 64) < 32));
      chk("free_st", period_strobe, (i >= 1) && ((i % 64) == 0));
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_hb", hb_pulse, 1'b0);
    chk("async_rst_st", period_strobe, 1'b0);
    chk("async_rst_pd", cfg_pending, 1'b0);
    do_reset();

    // BLINK 10/3 x2 followed by three dark periods.
    step(1'b1, 1'b1, 2'd2, 32'd10, 32'd3, 4'd2);
    run(130);

    // Mid-period load then overwrite before the boundary.
    do_reset();
    run(21);
    step(1'b1, 1'b1, 2'd1, 32'd8, 32'd2, 4'd1);
    run(5);
    step(1'b1, 1'b1, 2'd1, 32'd6, 32'd4, 4'd1);
    run(60);

    // SOLID, then OFF at a boundary, then enable drop mid-run with pending held.
    step(1'b1, 1'b1, 2'd3, 32'd5, 32'd1, 4'd0);
    run(20);
    step(1'b1, 1'b1, 2'd0, 32'd5, 32'd1, 4'd0);
    run(12);
    step(1'b1, 1'b1, 2'd1, 32'd9, 32'd4, 4'd0);
    run(4);
    step(1'b1, 1'b1, 2'd2, 32'd4, 32'd2, 4'd3);
    run(5);
    step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
    step(1'b0, 1'b1, 2'd1, 32'd3, 32'd1, 4'd0);
    run(10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp, rh;
      rp = 32'($urandom_range(0, 12));
      rh = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 14));
      step($urandom_range(0, 19) != 0, $urandom_range(0, 19) == 0,
           2'($urandom_range(0, 3)), rp, rh, 4'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hb_pattern_gen.md
Name: hb_pattern_gen

Overview:
Parametrised successor to the free-running heartbeat. Generates a registered heartbeat/status waveform with runtime-programmable period, high time and mode. Adds blink-code mode (N pulses, then a gap) so firmware-visible status can be shown on one LED. Sits at top level next to the linked-list core and drives the board LED and a period strobe for debug.

Parameters:
CNT_W, 32, width of the period/high-time counter and config fields
PERIOD_DEF, 64, period in clk cycles used after reset
HIGH_DEF, 32, high time in clk cycles used after reset
BLINK_W, 4, width of the blink-count field
GAP_PERIODS, 3, number of low periods inserted after each blink burst

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run generator; low forces output low and returns FSM to IDLE
cfg_load  in  1  one-cycle strobe; captures mode/period/high_time/blink_cnt into pending registers
mode  in  2  0=OFF, 1=FREE square, 2=BLINK code, 3=SOLID
period  in  CNT_W  cycles per period
high_time  in  CNT_W  high cycles per period
blink_cnt  in  BLINK_W  pulses per burst in BLINK mode
hb_pulse  out  1  registered heartbeat output
period_strobe  out  1  one-cycle pulse on the last cycle of every period (RUN and GAP)
cfg_pending  out  1  high while captured config has not yet been applied

Behaviour:
- Reset (async, reset_n=0): hb_pulse=0, period_strobe=0, cfg_pending=0, FSM=IDLE, cnt=0, active config = {mode=FREE, PERIOD_DEF, HIGH_DEF, blink_cnt=1}.
- Clamping applied when config becomes active: period<2 -> 2; high_time>=period -> period-1; high_time=0 is legal (output never high).
- FSM states: IDLE, RUN, GAP.
  IDLE: cnt=0, hb_pulse=0. If enable=1 and mode!=OFF -> RUN next edge, cnt=0.
  RUN: cnt increments each cycle, 0..period-1. hb_pulse registered = (cnt<high_time), so first high cycle appears the cycle after entering RUN (1-cycle latency). At cnt=period-1: period_strobe=1, cnt wraps to 0, blink index++.
  BLINK: after blink_cnt periods in RUN -> GAP. blink_cnt=0 -> go straight to GAP (output stays low).
  GAP: hb_pulse=0, counts GAP_PERIODS periods with period_strobe on each, then -> RUN, blink index=0.
  FREE: stays in RUN, never enters GAP.
  SOLID: RUN with hb_pulse=1 every cycle; period_strobe still generated.
  OFF: -> IDLE next edge, output low.
- Config update: cfg_load captures inputs into pending regs and sets cfg_pending. Applied (cfg_pending cleared) at the next period boundary (cnt=period-1 in RUN/GAP) or on the next edge if in IDLE. cfg_load during pending overwrites pending; cfg_load coincident with boundary: the new value is captured and applied at the following boundary.
- Mode change applies only at boundary, restarting from RUN with blink index=0.
- enable deassert: next edge -> IDLE, hb_pulse=0, period_strobe=0; pending config kept.
- enable and cfg_load in the same cycle: both honoured.
- Counter never overflows: compare against clamped period-1, no reliance on natural wrap.

Decomposition:
- Package hb_pkg: typedef enum hb_mode_e {HB_OFF, HB_FREE, HB_BLINK, HB_SOLID}; typedef enum hb_state_e {HB_IDLE, HB_RUN, HB_GAP}; constant HB_MIN_PERIOD=2.
- One sub-module natural: hb_period_cnt (CNT_W counter with wrap, last-cycle flag and high compare), instantiated once. FSM, config shadowing and clamping stay in hb_pattern_gen.

Test Plan:
- Reset defaults, enable=1, FREE: hb_pulse high cycles 1..32, low 33..64, period_strobe every 64 cycles; assert reset_n=0 mid-period -> outputs 0 immediately.
- cfg_load period=10, high_time=3, BLINK blink_cnt=2, GAP_PERIODS=3: after boundary, pattern = 3 high/7 low x2, then 30 low, repeat; 5 strobes per burst cycle.
- Clamp: period=1, high_time=5 -> effective period 2, high 1 (alternating 1/0); high_time=0 -> hb_pulse constantly 0, strobes continue.
- cfg_load mid-period (cnt=20 of 64): cfg_pending=1 until cycle cnt=63, new timing from next period; second cfg_load before boundary -> only second value used.
- SOLID then OFF: hb_pulse=1 continuously; OFF applied at boundary -> IDLE, output 0; enable low mid-RUN -> IDLE next edge.
- blink_cnt=0 in BLINK: hb_pulse stays 0, strobe every period, FSM cycles GAP only.
